// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports (W1 has priority), and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     w0_en,
    input  logic [ADDR_W-1:0]        w0_addr,
    input  logic [WIDTH-1:0]         w0_data,
    input  logic                     w1_en,
    input  logic [ADDR_W-1:0]        w1_addr,
    input  logic [WIDTH-1:0]         w1_data,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic                     busy_any
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    // Statement order encodes priority: W1 overrides W0 on a shared address,
    // and busy_set overrides a same-cycle clearing write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (w0_en) begin
                regs[w0_addr] <= w0_data;
                busy[w0_addr] <= 1'b0;
            end
            if (w1_en) begin
                regs[w1_addr] <= w1_data;
                busy[w1_addr] <= 1'b0;
            end
            if (busy_set) begin
                busy[busy_addr] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                regs[0] <= '0;
                busy[0] <= 1'b0;
            end
        end
    end

    assign busy_any = |busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        logic              bsy;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (!reset) begin
                if (w0_en && w0_addr == addr) begin
                    data = w0_data;
                    bsy  = 1'b0;
                end
                if (w1_en && w1_addr == addr) begin
                    data = w1_data;
                    bsy  = 1'b0;
                end
                if (busy_set && busy_addr == addr) begin
                    bsy = 1'b1;
                end
            end
`endif
            if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data;
        assign rd_busy[p]                = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters): directed vector table,
// same-cycle forwarding sequences, and randomized traffic against a reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        w0_en, w1_en, busy_set;
    logic [4:0]  w0_addr, w1_addr, busy_addr;
    logic [31:0] w0_data, w1_data;
    logic        busy_any;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    regfile_mp #(.WIDTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .w0_en     (w0_en),
        .w0_addr   (w0_addr),
        .w0_data   (w0_data),
        .w1_en     (w1_en),
        .w1_addr   (w1_addr),
        .w1_data   (w1_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy_any  (busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w0_en;
        logic [4:0]  w0_addr;
        logic [31:0] w0_data;
        logic        w1_en;
        logic [4:0]  w1_addr;
        logic [31:0] w1_data;
        logic        bs;
        logic [4:0]  bs_addr;
        logic [4:0]  chk;
        logic [31:0] exp_d;
        logic        exp_b;
        logic        exp_any;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        w0_en = 1'b0; w0_addr = '0; w0_data = '0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0;
        busy_set = 1'b0; busy_addr = '0;
    endtask

    // Reference state update from the architectural rules, using the inputs present at the edge.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (w0_en && !(w1_en && w1_addr == w0_addr)) begin
                m_mem[w0_addr]  = w0_data;
                m_busy[w0_addr] = 1'b0;
            end
            if (w1_en) begin
                m_mem[w1_addr]  = w1_data;
                m_busy[w1_addr] = 1'b0;
            end
            if (busy_set) m_busy[busy_addr] = 1'b1;
            m_mem[0]  = '0;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (!reset) begin
            if (w1_en && w1_addr == a) begin
                d = w1_data; b = 1'b0;
            end else if (w0_en && w0_addr == a) begin
                d = w0_data; b = 1'b0;
            end
            if (busy_set && busy_addr == a) b = 1'b1;
        end
`endif
        if (a == 5'd0) begin
            d = '0; b = 1'b0;
        end
    endtask

    function automatic logic model_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_busy[i];
        return r;
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ed;
        logic        eb;
        logic [4:0]  a0, a1;

        reset = 1'b1;
        rd_addr = '0;
        clear_inputs();
        cycle();
        reset = 1'b0;
        #2;
        rd_addr = {5'd31, 5'd5};
        #1;
        chk("init_d0", rd_data[31:0], 32'h0);
        chk("init_d1", rd_data[63:32], 32'h0);
        chk("init_busy", {30'd0, rd_busy}, 32'h0);
        chk("init_any", {31'd0, busy_any}, 32'h0);

        // Random writes and claims, then a single reset cycle clears everything.
        for (int i = 0; i < 20; i++) begin
            w0_en = 1'b1; w0_addr = 5'($urandom); w0_data = $urandom;
            w1_en = 1'b1; w1_addr = 5'($urandom); w1_data = $urandom;
            busy_set = 1'b1; busy_addr = 5'($urandom_range(1, 31));
            cycle();
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_inputs();
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("rst_d0_r%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("rst_b0_r%0d", a), {31'd0, rd_busy[0]}, 32'h0);
            chk($sformatf("rst_d1_r%0d", 31 - a), rd_data[63:32], 32'h0);
        end
        chk("rst_any", {31'd0, busy_any}, 32'h0);

        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd7, 32'h1111,     1'b1, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 32'h2222,     1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd8, 32'h3,        1'b1, 5'd9, 32'h4,    1'b0, 5'd0, 5'd8, 32'h3,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd9, 32'h4,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 32'h0,        1'b1, 1'b1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h9,    1'b0, 5'd0, 5'd3, 32'h9,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 5'd4, 32'h0,        1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'd4, 32'h6,        1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 5'd4, 32'h6,        1'b1, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h7,    1'b0, 5'd0, 5'd4, 32'h7,        1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'd2, 32'h5,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd2, 32'h5,        1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            w0_en = vecs[i].w0_en; w0_addr = vecs[i].w0_addr; w0_data = vecs[i].w0_data;
            w1_en = vecs[i].w1_en; w1_addr = vecs[i].w1_addr; w1_data = vecs[i].w1_data;
            busy_set = vecs[i].bs; busy_addr = vecs[i].bs_addr;
            cycle();
            clear_inputs();
            rd_addr = {vecs[i].chk, vecs[i].chk};
            #2;
            chk($sformatf("vec%0d_d0", i), rd_data[31:0], vecs[i].exp_d);
            chk($sformatf("vec%0d_d1", i), rd_data[63:32], vecs[i].exp_d);
            chk($sformatf("vec%0d_b0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].exp_b});
            chk($sformatf("vec%0d_b1", i), {31'd0, rd_busy[1]}, {31'd0, vecs[i].exp_b});
            chk($sformatf("vec%0d_any", i), {31'd0, busy_any}, {31'd0, vecs[i].exp_any});
        end

        // Same-cycle write/read of r10.
        w0_en = 1'b1; w0_addr = 5'd10; w0_data = 32'h1;
        cycle();
        w0_data = 32'h2;
        rd_addr = {5'd0, 5'd10};
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("fwd_r10_same", rd_data[31:0], 32'h2);
`else
        chk("fwd_r10_same", rd_data[31:0], 32'h1);
`endif
        cycle();
        clear_inputs();
        #2;
        chk("fwd_r10_next", rd_data[31:0], 32'h2);

        // Busy r11 being cleared by W1 in the cycle it is read.
        busy_set = 1'b1; busy_addr = 5'd11;
        cycle();
        clear_inputs();
        w1_en = 1'b1; w1_addr = 5'd11; w1_data = 32'h55;
        rd_addr = {5'd11, 5'd0};
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("fwd_r11_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("fwd_r11_data", rd_data[63:32], 32'h55);
`else
        chk("fwd_r11_busy", {31'd0, rd_busy[1]}, 32'h1);
        chk("fwd_r11_data", rd_data[63:32], 32'h0);
`endif
        // A write to r0 is never forwarded.
        w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFF;
        #1;
        chk("fwd_r0_data", rd_data[31:0], 32'h0);
        cycle();
        clear_inputs();
        #2;
        chk("r11_after", rd_data[63:32], 32'h55);

        // Randomized traffic concentrated on a few registers to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            w0_en = 1'($urandom); w0_addr = 5'($urandom_range(0, 7)); w0_data = $urandom;
            w1_en = 1'($urandom); w1_addr = 5'($urandom_range(0, 7)); w1_data = $urandom;
            busy_set = 1'($urandom); busy_addr = 5'($urandom_range(0, 7));
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            rd_addr = {a1, a0};
            #2;
            model_read(a0, ed, eb);
            chk($sformatf("rnd%0d_d0", i), rd_data[31:0], ed);
            chk($sformatf("rnd%0d_b0", i), {31'd0, rd_busy[0]}, {31'd0, eb});
            model_read(a1, ed, eb);
            chk($sformatf("rnd%0d_d1", i), rd_data[63:32], ed);
            chk($sformatf("rnd%0d_b1", i), {31'd0, rd_busy[1]}, {31'd0, eb});
            chk($sformatf("rnd%0d_any", i), {31'd0, busy_any}, {31'd0, model_any()});
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
